// File: rtl/root_search_if.sv
// Handshake bundle between the root search controller and its plant/host.
// The master side issues searches and answers measurements; the slave is the controller.
interface root_search_if #(
  parameter int BUS_WIDTH = 10,
  parameter int ITER_W    = 5
);
  logic                 start;
  logic                 mode;
  logic [BUS_WIDTH-1:0] i_ref_setup;
  logic [BUS_WIDTH-1:0] q_desired;
  logic                 meas_valid;
  logic [BUS_WIDTH-1:0] q_measured;
  logic [BUS_WIDTH-1:0] i_ref;
  logic                 meas_req;
  logic                 busy;
  logic                 converged;
  logic                 went_unstable;
  logic [ITER_W-1:0]    iter_count;

  modport master (
    output start, mode, i_ref_setup, q_desired,
    output meas_valid, q_measured,
    input  i_ref, meas_req, busy,
    input  converged, went_unstable, iter_count
  );

  modport slave (
    input  start, mode, i_ref_setup, q_desired,
    input  meas_valid, q_measured,
    output i_ref, meas_req, busy,
    output converged, went_unstable, iter_count
  );
endinterface

// File: rtl/root_search_ctrl.sv
// Drives a monotonic plant toward q_desired by bisection or secant search.
// One measurement per MEAS visit; sticky converged/went_unstable outcome.
module root_search_ctrl #(
  parameter int BUS_WIDTH = 10,
  parameter int TOL       = 1,
  parameter int MAX_ITER  = 16,
  parameter int ITER_W    = $clog2(MAX_ITER + 1)
) (
  input logic clk,
  input logic rst,
  root_search_if.slave bus
);

  localparam int BW = BUS_WIDTH;
  localparam int PW = 2 * BW + 2;
  localparam logic signed [BW:0] TOL_S = (BW + 1)'(TOL);
  localparam logic [ITER_W-1:0] MAX_IT = ITER_W'(MAX_ITER);
  localparam logic [BW-1:0] ONE = {{(BW - 1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    MEAS,
    EVAL,
    CALC,
    DONE
  } state_t;

  state_t state;

  logic              mode_r;
  logic [BW-1:0]     qd;
  logic [BW-1:0]     qm;
  logic [BW-1:0]     lo;
  logic [BW-1:0]     hi;
  logic [BW-1:0]     x0;
  logic [BW-1:0]     x1;
  logic signed [BW:0] e0;
  logic signed [BW:0] e1;
  logic [BW-1:0]     i_ref;
  logic              meas_req;
  logic              busy;
  logic              converged;
  logic              unstable;
  logic [ITER_W-1:0] iter;

  logic signed [BW:0]   e_cur;
  logic                 conv_hit;
  logic                 e_pos;
  logic [BW-1:0]        nlo;
  logic [BW-1:0]        nhi;
  logic [BW-1:0]        nspan;
  logic [BW-1:0]        nmid;
  logic signed [BW:0]   dx;
  logic signed [PW-1:0] num;
  logic signed [BW+1:0] den;
  logic signed [PW-1:0] den_ext;
  logic signed [PW-1:0] quo;
  logic signed [PW-1:0] x2w;
  logic [BW-1:0]        x2c;

  always_comb begin
    e_cur    = $signed({1'b0, qd}) - $signed({1'b0, qm});
    conv_hit = (e_cur <= TOL_S) && (e_cur >= -TOL_S);
    e_pos    = !e_cur[BW] && (e_cur != '0);
    nlo      = e_pos ? i_ref : lo;
    nhi      = e_pos ? hi : i_ref;
    nspan    = nhi - nlo;
    nmid     = nlo + (nspan >> 1);
    dx       = $signed({1'b0, x1}) - $signed({1'b0, x0});
    num      = $signed({{(PW - BW - 1){e1[BW]}}, e1})
             * $signed({{(PW - BW - 1){dx[BW]}}, dx});
    den      = $signed({e1[BW], e1}) - $signed({e0[BW], e0});
    den_ext  = $signed({{(PW - BW - 2){den[BW+1]}}, den});
    // Guard only; CALC never uses the quotient when e1 == e0.
    if (den == '0) begin
      den_ext = {{(PW - 1){1'b0}}, 1'b1};
    end
    quo = num / den_ext;
    x2w = $signed({{(PW - BW){1'b0}}, x1}) - quo;
    if (x2w[PW-1]) begin
      x2c = '0;
    end else if (|x2w[PW-2:BW]) begin
      x2c = '1;
    end else begin
      x2c = x2w[BW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_r    <= 1'b0;
      qd        <= '0;
      qm        <= '0;
      lo        <= '0;
      hi        <= '0;
      x0        <= '0;
      x1        <= '0;
      e0        <= '0;
      e1        <= '0;
      i_ref     <= '0;
      meas_req  <= 1'b0;
      busy      <= 1'b0;
      converged <= 1'b0;
      unstable  <= 1'b0;
      iter      <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= MEAS;
            mode_r    <= bus.mode;
            qd        <= bus.q_desired;
            lo        <= '0;
            hi        <= bus.i_ref_setup;
            x0        <= '0;
            x1        <= bus.i_ref_setup;
            e0        <= '0;
            e1        <= '0;
            i_ref     <= bus.mode ? '0 : (bus.i_ref_setup >> 1);
            meas_req  <= 1'b1;
            busy      <= 1'b1;
            converged <= 1'b0;
            unstable  <= 1'b0;
            iter      <= '0;
          end
        end
        MEAS: begin
          if (bus.meas_valid) begin
            qm       <= bus.q_measured;
            iter     <= iter + ITER_W'(1);
            meas_req <= 1'b0;
            state    <= EVAL;
          end
        end
        EVAL: begin
          if (conv_hit) begin
            converged <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else if (iter == MAX_IT) begin
            unstable <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else if (!mode_r) begin
            lo <= nlo;
            hi <= nhi;
            if (nspan <= ONE) begin
              unstable <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              i_ref    <= nmid;
              meas_req <= 1'b1;
              state    <= MEAS;
            end
          end else if (iter == ITER_W'(1)) begin
            e0       <= e_cur;
            i_ref    <= x1;
            meas_req <= 1'b1;
            state    <= MEAS;
          end else begin
            e1    <= e_cur;
            state <= CALC;
          end
        end
        CALC: begin
          if (den == '0 || x2c == x1) begin
            unstable <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            x0       <= x1;
            e0       <= e1;
            x1       <= x2c;
            i_ref    <= x2c;
            meas_req <= 1'b1;
            state    <= MEAS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_ref         = i_ref;
  assign bus.meas_req      = meas_req;
  assign bus.busy          = busy;
  assign bus.converged     = converged;
  assign bus.went_unstable = unstable;
  assign bus.iter_count    = iter;

endmodule

// File: tb/tb_root_search_ctrl.sv
// Scoreboard bench: stimulus queues expected i_ref steps and search outcomes,
// a monitor pops them on meas_req rises and busy falls.
module tb_root_search_ctrl;

  localparam int BW = 10;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  root_search_if #(.BUS_WIDTH(BW), .ITER_W(IW)) bus ();

  root_search_ctrl #(
    .BUS_WIDTH(BW),
    .TOL(1),
    .MAX_ITER(16),
    .ITER_W(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic plant_valid = 1'b0;
  logic spur_valid  = 1'b0;
  logic flat        = 1'b0;

  assign bus.meas_valid = plant_valid | spur_valid;
  assign bus.q_measured = flat ? 10'd50 : (bus.i_ref >> 2);

  typedef struct packed {
    logic          conv;
    logic          unst;
    logic [IW-1:0] iter;
    logic [BW-1:0] iref;
  } res_t;

  res_t exp_res[$];
  int   exp_meas[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_res(logic c, logic u, int it, int ir);
    res_t r;
    r.conv = c;
    r.unst = u;
    r.iter = IW'(it);
    r.iref = BW'(ir);
    exp_res.push_back(r);
  endtask

  // Plant: answers each new meas_req two cycles later.
  logic p_prev = 1'b0;
  int   p_cd   = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        plant_valid = 1'b0;
        p_cd = 0;
      end else if (bus.meas_req && !p_prev) begin
        p_cd = 1;
        plant_valid = 1'b0;
      end else if (p_cd == 1) begin
        plant_valid = 1'b1;
        p_cd = 0;
      end else begin
        plant_valid = 1'b0;
      end
      p_prev = bus.meas_req;
    end
  end

  logic m_pb = 1'b0;
  logic m_pm = 1'b0;
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst && bus.meas_req === 1'b1 && !m_pm) begin
        if (exp_meas.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL meas_unexpected: got i_ref %0d, required none",
                   bus.i_ref);
        end else begin
          check("meas_i_ref", int'(bus.i_ref), exp_meas.pop_front());
        end
      end
      if (!rst && m_pb && bus.busy === 1'b0) begin
        if (exp_res.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL res_unexpected: got done, required none");
        end else begin
          r = exp_res.pop_front();
          check("res_converged", int'(bus.converged), int'(r.conv));
          check("res_unstable", int'(bus.went_unstable), int'(r.unst));
          check("res_iter", int'(bus.iter_count), int'(r.iter));
          check("res_i_ref", int'(bus.i_ref), int'(r.iref));
        end
      end
      m_pb = (bus.busy === 1'b1);
      m_pm = (bus.meas_req === 1'b1);
    end
  end

  task automatic launch(logic m, int setup, int qd);
    @(negedge clk);
    bus.mode        = m;
    bus.i_ref_setup = BW'(setup);
    bus.q_desired   = BW'(qd);
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int k = 0;
    while (bus.busy !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got busy %0d, required 0", name, bus.busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_i_ref"}, int'(bus.i_ref), 0);
    check({tag, "_meas_req"}, int'(bus.meas_req), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_converged"}, int'(bus.converged), 0);
    check({tag, "_unstable"}, int'(bus.went_unstable), 0);
    check({tag, "_iter"}, int'(bus.iter_count), 0);
  endtask

  initial begin
    int k;
    bus.start       = 1'b0;
    bus.mode        = 1'b0;
    bus.i_ref_setup = '0;
    bus.q_desired   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Bisection converging.
    foreach (exp_meas[i]) exp_meas.delete(i);
    exp_meas.push_back(511);
    exp_meas.push_back(255);
    exp_meas.push_back(383);
    exp_meas.push_back(447);
    push_res(1'b1, 1'b0, 4, 447);
    launch(1'b0, 1023, 110);
    wait_idle("bisect");

    // Secant converging.
    exp_meas.push_back(0);
    exp_meas.push_back(1023);
    exp_meas.push_back(161);
    push_res(1'b1, 1'b0, 3, 161);
    launch(1'b1, 1023, 40);
    wait_idle("secant");

    // Bisection with unreachable target.
    begin
      int seq[10] = '{511, 767, 895, 959, 991, 1007, 1015, 1019, 1021, 1022};
      foreach (seq[i]) exp_meas.push_back(seq[i]);
    end
    push_res(1'b0, 1'b1, 10, 1022);
    launch(1'b0, 1023, 300);
    wait_idle("bisect_unreach");

    // Secant on a flat plant.
    flat = 1'b1;
    exp_meas.push_back(0);
    exp_meas.push_back(1023);
    push_res(1'b0, 1'b1, 2, 1023);
    launch(1'b1, 1023, 100);
    wait_idle("secant_flat");
    flat = 1'b0;

    // Start pulsed mid-search must be ignored.
    exp_meas.push_back(511);
    exp_meas.push_back(255);
    exp_meas.push_back(383);
    exp_meas.push_back(447);
    push_res(1'b1, 1'b0, 4, 447);
    launch(1'b0, 1023, 110);
    repeat (2) @(negedge clk);
    bus.mode        = 1'b1;
    bus.i_ref_setup = 10'd500;
    bus.q_desired   = 10'd40;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("start_busy");

    // Reset during the third MEAS of the bisection run.
    exp_meas.push_back(511);
    exp_meas.push_back(255);
    exp_meas.push_back(383);
    launch(1'b0, 1023, 110);
    k = 0;
    while (!(bus.meas_req && bus.iter_count == IW'(2)) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("third_meas_reached", int'(bus.iter_count), 2);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    spur_valid = 1'b1;
    repeat (2) @(negedge clk);
    spur_valid = 1'b0;
    @(negedge clk);
    check("spur_iter", int'(bus.iter_count), 0);
    check("spur_busy", int'(bus.busy), 0);
    check("spur_meas_req", int'(bus.meas_req), 0);

    repeat (3) @(negedge clk);
    check("queues_empty", exp_meas.size() + exp_res.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/root_search_ctrl.md
ROOT_SEARCH_CTRL -- requirements
Module: root_search_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  BUS_WIDTH, 10, width of i_ref / q buses
  TOL, 1, convergence band: |q_desired - q_measured| <= TOL
  MAX_ITER, 16, measurement budget per search
  ITER_W, $clog2(MAX_ITER+1), iter_count width
REQ-002 Ports SHALL be (name direction width meaning):
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  synchronous, active-high reset
  start  in  1  one-cycle pulse, begins a search; sampled only in IDLE or DONE
  mode  in  1  0 = bisection, 1 = secant; sampled with start
  i_ref_setup  in  BUS_WIDTH  upper search bound; sampled with start
  q_desired  in  BUS_WIDTH  target; sampled with start
  meas_valid  in  1  q_measured valid for current i_ref
  q_measured  in  BUS_WIDTH  plant response
  i_ref  out  BUS_WIDTH  drive current reference
  meas_req  out  1  measurement requested at i_ref
  busy  out  1  search in progress
  converged  out  1  sticky success flag
  went_unstable  out  1  sticky failure flag
  iter_count  out  ITER_W  measurements completed in this search

Function
REQ-003 Plant SHALL be treated as monotonic non-decreasing; error e = q_desired - q_measured, signed BUS_WIDTH+1 bits.
REQ-004 FSM states SHALL be IDLE, MEAS, EVAL, CALC, DONE; busy = 1 in MEAS, EVAL, CALC.
REQ-005 start in IDLE/DONE: next cycle state MEAS, flags and iter_count cleared, meas_req = 1; start while busy ignored.
REQ-006 Initial points: bisection lo = 0, hi = i_ref_setup, first i_ref = (lo+hi)>>1; secant x0 = 0 measured first, then x1 = i_ref_setup.
REQ-007 MEAS: meas_req held 1 and i_ref stable until meas_valid = 1; that cycle captures q_measured, increments iter_count, goes to EVAL; meas_valid outside MEAS ignored.
REQ-008 EVAL (one cycle): |e| <= TOL -> DONE, converged = 1, i_ref held; checked before any other rule.
REQ-009 Bisection EVAL: e > 0 -> lo = i_ref, else hi = i_ref; if hi - lo <= 1 -> DONE, went_unstable = 1; else i_ref = (lo+hi)>>1, MEAS.
REQ-010 Secant EVAL: after first measurement store e0, i_ref = x1, MEAS; afterwards go to CALC.
REQ-011 CALC (one cycle): x2 = x1 - e1*(x1-x0)/(e1-e0); signed product 2*BUS_WIDTH+2 bits, division truncates toward zero, result clamped to [0, 2^BUS_WIDTH-1].
REQ-012 CALC: e1 == e0 -> DONE, went_unstable = 1, no division; clamped x2 == x1 -> DONE, went_unstable = 1; else x0 = x1, e0 = e1, x1 = i_ref = x2, MEAS.
REQ-013 iter_count == MAX_ITER in EVAL without convergence -> DONE, went_unstable = 1.
REQ-014 converged and went_unstable SHALL be mutually exclusive and held in DONE until next start or rst.

Reset
REQ-015 rst = 1 at a clock edge: state IDLE; i_ref, iter_count = 0; meas_req, busy, converged, went_unstable = 0; internal lo/hi/x/e registers cleared.
REQ-016 rst SHALL override start, meas_valid and any state, including mid-MEAS and mid-CALC.

Verification
Plant model q = i_ref>>2, BUS_WIDTH = 10, TOL = 1, meas_valid 2 cycles after meas_req rises.
REQ-017 Bisection, q_desired = 110, setup = 1023 -> i_ref sequence 511, 255, 383, 447; converged = 1, iter_count = 4, i_ref = 447.
REQ-018 Secant, q_desired = 40, setup = 1023 -> i_ref 0, 1023, 161; converged = 1, iter_count = 3.
REQ-019 Bisection, q_desired = 300 (unreachable) -> last i_ref 1022, went_unstable = 1, iter_count = 10.
REQ-020 Secant, plant constant q = 50, q_desired = 100 -> went_unstable = 1 after 2 measurements, i_ref = 1023.
REQ-021 rst asserted during third MEAS of REQ-017 -> next cycle all outputs at reset values; spurious meas_valid in IDLE leaves iter_count = 0.
REQ-022 start pulsed while busy -> ignored; search result identical to REQ-017.
